// File: rtl/pingpong_bank_buffer_pkg.sv
// Shared definitions for the multi-bank ping-pong buffer: sizing helper,
// read FSM encoding and default geometry.
package pingpong_bank_buffer_pkg;

  localparam int unsigned DEF_WIDTH     = 8;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned DEF_NUM_BANKS = 2;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } rd_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned bits;
    bits = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/pingpong_bank_buffer_bank_mem.sv
// Banked word storage: one write port, one registered read port, each
// addressed by {bank, word}. Read data holds while no read is issued.
module bank_mem
  import pingpong_bank_buffer_pkg::*;
#(
  parameter  int unsigned WIDTH     = DEF_WIDTH,
  parameter  int unsigned DEPTH     = DEF_DEPTH,
  parameter  int unsigned NUM_BANKS = DEF_NUM_BANKS,
  localparam int unsigned AW        = clog2(DEPTH),
  localparam int unsigned BW        = clog2(NUM_BANKS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [BW-1:0]    wr_bank,
  input  logic [AW-1:0]    wr_word,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [BW-1:0]    rd_bank,
  input  logic [AW-1:0]    rd_word,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [NUM_BANKS][DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_bank][wr_word] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_bank][rd_word];
    end
  end

endmodule

// File: rtl/pingpong_bank_buffer.sv
// NUM_BANKS x DEPTH ping-pong buffer: producer fills banks in order, consumer
// drains only completed banks in fill order with one-cycle read latency.
module pingpong_bank_buffer
  import pingpong_bank_buffer_pkg::*;
#(
  parameter  int unsigned WIDTH     = DEF_WIDTH,
  parameter  int unsigned DEPTH     = DEF_DEPTH,
  parameter  int unsigned NUM_BANKS = DEF_NUM_BANKS,
  localparam int unsigned AW        = clog2(DEPTH),
  localparam int unsigned BW        = clog2(NUM_BANKS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_vld,
  input  logic                 read,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_vld,
  output logic                 dout_last,
  output logic [BW-1:0]        dout_bank,
  output logic [NUM_BANKS-1:0] status_vld,
  output logic                 full,
  output logic                 empty,
  output logic                 wr_error,
  output logic                 rd_error
);

  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

  logic [BW-1:0]        w_bank, r_bank;
  logic [AW-1:0]        w_cnt, r_cnt;
  logic [NUM_BANKS-1:0] status_q, status_nxt;
  rd_state_e            state, state_nxt;

  logic wr_accept, wr_last;
  logic rd_avail, rd_accept, rd_last;

  assign status_vld = status_q;
  assign full       = status_q[w_bank];
  assign empty      = ~|status_q;

  // A bank stays readable for its whole burst, so one availability test
  // covers both the burst start and every word within it.
  always_comb begin
    wr_last   = (w_cnt == LAST_WORD);
    wr_accept = din_vld && !full && !flush;
    rd_last   = (r_cnt == LAST_WORD);
    rd_avail  = status_q[r_bank];
    rd_accept = read && rd_avail && !flush;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = R_IDLE;
    end else begin
      case (state)
        R_IDLE:  if (rd_accept && !rd_last) state_nxt = R_BURST;
        R_BURST: if (rd_accept && rd_last)  state_nxt = R_IDLE;
        default: state_nxt = R_IDLE;
      endcase
    end
  end

  // Writer only completes a bank it found empty and reader only drains a
  // bank it found full, so the set and clear never hit the same bit.
  always_comb begin
    status_nxt = status_q;
    if (flush) begin
      status_nxt = '0;
    end else begin
      if (wr_accept && wr_last) status_nxt[w_bank] = 1'b1;
      if (rd_accept && rd_last) status_nxt[r_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= R_IDLE;
      status_q <= '0;
    end else begin
      state    <= state_nxt;
      status_q <= status_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_bank    <= '0;
      w_cnt     <= '0;
      r_bank    <= '0;
      r_cnt     <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      dout_bank <= '0;
      wr_error  <= 1'b0;
      rd_error  <= 1'b0;
    end else if (flush) begin
      w_bank    <= '0;
      w_cnt     <= '0;
      r_bank    <= '0;
      r_cnt     <= '0;
      dout_vld  <= 1'b0;
      dout_last <= 1'b0;
      wr_error  <= 1'b0;
      rd_error  <= 1'b0;
    end else begin
      if (wr_accept) begin
        if (wr_last) begin
          w_cnt  <= '0;
          w_bank <= (w_bank == LAST_BANK) ? '0 : w_bank + 1'b1;
        end else begin
          w_cnt <= w_cnt + 1'b1;
        end
      end
      if (rd_accept) begin
        dout_bank <= r_bank;
        if (rd_last) begin
          r_cnt  <= '0;
          r_bank <= (r_bank == LAST_BANK) ? '0 : r_bank + 1'b1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      dout_vld  <= rd_accept;
      dout_last <= rd_accept && rd_last;
      wr_error  <= din_vld && full;
      rd_error  <= read && !rd_avail;
    end
  end

  bank_mem #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .NUM_BANKS (NUM_BANKS)
  ) u_bank_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_accept),
    .wr_bank (w_bank),
    .wr_word (w_cnt),
    .wr_data (din),
    .rd_en   (rd_accept),
    .rd_bank (r_bank),
    .rd_word (r_cnt),
    .rd_data (dout)
  );

endmodule

// File: doc/pingpong_bank_buffer.md
Name: pingpong_bank_buffer

Overview:
Single-clock, parametrised multi-bank ping-pong buffer. It generalises the existing 2-bank write_ctrl/read_ctrl pair to NUM_BANKS banks of DEPTH words by WIDTH bits, with on-chip storage. A producer fills banks word by word. A consumer drains only completed banks, in fill order. It sits between a switch/packet source and a display or stream sink, and reports per-bank valid status, full, empty and separate write/read errors.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 4, words per bank (>=2)
NUM_BANKS, 2, number of banks (>=2)
AW, derived clog2(DEPTH), word index width (localparam)
BW, derived clog2(NUM_BANKS), bank index width (localparam)

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of all buffer state
din  in  WIDTH  write data
din_vld  in  1  write strobe, one word per cycle high
read  in  1  read request, one word per cycle high
dout  out  WIDTH  read data, registered
dout_vld  out  1  dout valid, one-cycle pulse per accepted read
dout_last  out  1  qualifies dout_vld; last word of a bank
dout_bank  out  BW  bank index of current dout
status_vld  out  NUM_BANKS  bit b = bank b complete and not yet drained
full  out  1  current write bank still holds undrained data
empty  out  1  no complete bank available
wr_error  out  1  one-cycle pulse: din_vld dropped because full
rd_error  out  1  one-cycle pulse: read rejected because no complete bank

Behaviour:
- Reset (rst high, async): pointers, counters and status_vld = 0; dout = 0; dout_vld, dout_last, wr_error, rd_error = 0; dout_bank = 0. Outputs: full = 0, empty = 1.
- full = status_vld[w_bank], combinational from registers. empty = ~|status_vld.
- Write side:
  - din_vld && !full writes mem[w_bank][w_cnt] <= din and increments w_cnt.
  - On the write with w_cnt == DEPTH-1: set status_vld[w_bank] at that edge, clear w_cnt, advance w_bank modulo NUM_BANKS.
- Write when full: the word is dropped, no state change, wr_error = 1 the next cycle.
- Partial banks are never readable.
- Read FSM has two states:
  - R_IDLE: r_cnt == 0. read && status_vld[r_bank] -> R_BURST, unless DEPTH words are already consumed.
  - R_BURST: mid-bank.
  - Each accepted read drives, one cycle later: dout = mem[r_bank][r_cnt], dout_vld = 1, dout_bank = r_bank, dout_last = (r_cnt == DEPTH-1). Latency is 1 cycle; back-to-back reads give one word per cycle.
  - On the last word, clear status_vld[r_bank], advance r_bank modulo NUM_BANKS, set r_cnt = 0, return to R_IDLE.
- Read when !status_vld[r_bank]: rd_error = 1 next cycle, dout_vld = 0. Cannot occur in R_BURST.
- dout holds its last value while dout_vld = 0.
- Simultaneous events:
  - A write completing bank X and a read draining bank Y in the same cycle both take effect; the set and clear hit different bits.
  - The write and read pointers never address the same bank while it is writable and readable, since full blocks the writer.
  - A write into a bank being freed in the same cycle is not accepted; full is evaluated on pre-edge state.
- flush: synchronous; highest priority over din_vld and read in the same cycle. Clears status_vld, pointers, counters and FSM; forces dout_vld, wr_error and rd_error to 0 next cycle. dout data holds. Memory contents are not cleared.
- Counters wrap exactly at DEPTH-1 and NUM_BANKS-1. Non-power-of-2 values must work.

Decomposition:
- Shared package: clog2 function; read FSM state encoding (R_IDLE, R_BURST); default WIDTH/DEPTH/NUM_BANKS constants.
- One sub-module: bank_mem. It is a NUM_BANKS*DEPTH x WIDTH register array with one write port and one registered read port, addressed {bank, word}.
- Controller and pointers live in the top module.

Test Plan (WIDTH=8, DEPTH=4, NUM_BANKS=2 unless noted):
- Reset, then write 0x11,0x22,0x33,0x44 -> status_vld = 2'b01 after 4th edge; full = 0; empty = 0.
- Fill both banks (0x11..0x44, 0x55..0x88), then din_vld with 0x99 -> full = 1; wr_error pulses 1 cycle; 0x99 is never read.
- 4 back-to-back reads after one full bank -> dout 0x11,0x22,0x33,0x44 on consecutive cycles, each with dout_vld = 1; dout_last only on 0x44; dout_bank = 0; status_vld[0] clears; empty = 1.
- Read with empty, and read after 2 of 4 words written -> rd_error pulse, dout_vld = 0, dout unchanged.
- Same-cycle 4th write to bank 1 and last read of bank 0 -> next cycle status_vld = 2'b10; no errors.
- Mid-burst flush with read high -> dout_vld = 0 next cycle; status_vld = 0; empty = 1; the next fill lands in bank 0. Repeat with NUM_BANKS=3, DEPTH=5 to check wrap.
